backing_mem: RTL and testbench

BACKING_MEM -- requirements
Module: backing_mem

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_array.sv | 29 ++
 rtl/backing_mem.sv | 116 +++++++++++
 tb/tb_backing_mem.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the backing memory model: FSM state encoding,
// default geometry and the latency counter width.
package mem_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADD_WIDTH  = 12;

  // Both latencies are at most 15, so 4 bits always hold (latency - 1).
  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } mem_state_e;

  // Counter preload for an operation that takes 'latency' cycles.
  function automatic logic [CNT_WIDTH-1:0] latency_load(input int latency);
    return CNT_WIDTH'(latency - 1);
  endfunction

endpackage : mem_pkg

// File: rtl/mem_array.sv
// Word storage: one synchronous write port and one asynchronous read port.
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADD_WIDTH  = DEFAULT_ADD_WIDTH
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADD_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADD_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADD_WIDTH];

  // Synchronous write of one word when enabled.
  // NOTE: the storage has no reset branch on purpose; contents survive reset
  // and a reset loop over the array would not map onto RAM.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : mem_array

// File: rtl/backing_mem.sv
// Backing memory behind a cache: accepts one read, one write, or a combined
// write-then-read request while idle and serves it after fixed latencies.
module backing_mem
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADD_WIDTH     = DEFAULT_ADD_WIDTH,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m_ren,
  input  logic [ADD_WIDTH-1:0]  m_rd_address,
  input  logic                  m_wen,
  input  logic [ADD_WIDTH-1:0]  m_wr_address,
  input  logic [DATA_WIDTH-1:0] m_data_out,
  output logic [DATA_WIDTH-1:0] m_data_in,
  output logic                  m_rdata_valid,
  output logic                  m_busy
);

  localparam logic [CNT_WIDTH-1:0] RD_LOAD = latency_load(READ_LATENCY);
  localparam logic [CNT_WIDTH-1:0] WR_LOAD = latency_load(WRITE_LATENCY);

  mem_state_e            state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  rd_pending;
  logic [ADD_WIDTH-1:0]  rd_addr;
  logic [ADD_WIDTH-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  array_we;
  logic                  cnt_done;

  assign cnt_done = (cnt == '0);

  // A reset on the update edge wins, so an unfinished write never lands.
  assign array_we = (state == WRITE) && cnt_done && !reset;

  assign m_busy = (state != IDLE);

  mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADD_WIDTH  (ADD_WIDTH)
  ) u_array (
    .clock (clock),
    .we    (array_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Request FSM: sample in IDLE, count down the latency, then complete.
  // NOTE: all state here uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      rd_pending    <= 1'b0;
      rd_addr       <= '0;
      wr_addr       <= '0;
      wr_data       <= '0;
      m_data_in     <= '0;
      m_rdata_valid <= 1'b0;
    end else begin
      m_rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (m_wen) begin
            wr_addr    <= m_wr_address;
            wr_data    <= m_data_out;
            cnt        <= WR_LOAD;
            rd_pending <= m_ren;
            if (m_ren) begin
              rd_addr <= m_rd_address;
            end
            state <= WRITE;
          end else if (m_ren) begin
            rd_addr <= m_rd_address;
            cnt     <= RD_LOAD;
            state   <= READ;
          end
        end
        WRITE: begin
          if (cnt_done) begin
            if (rd_pending) begin
              rd_pending <= 1'b0;
              cnt        <= RD_LOAD;
              state      <= READ;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        READ: begin
          if (cnt_done) begin
            m_data_in     <= rd_data;
            m_rdata_valid <= 1'b1;
            state         <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : backing_mem

// File: tb/tb_backing_mem.sv
// Directed bench for backing_mem with default latencies (read 4, write 2).
module tb_backing_mem;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int RL = 4;
  localparam int WL = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          m_ren = 1'b0;
  logic [AW-1:0] m_rd_address = '0;
  logic          m_wen = 1'b0;
  logic [AW-1:0] m_wr_address = '0;
  logic [DW-1:0] m_data_out = '0;
  logic [DW-1:0] m_data_in;
  logic          m_rdata_valid;
  logic          m_busy;

  int tests_run = 0;
  int failed    = 0;

  backing_mem #(
    .DATA_WIDTH    (DW),
    .ADD_WIDTH     (AW),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .m_ren         (m_ren),
    .m_rd_address  (m_rd_address),
    .m_wen         (m_wen),
    .m_wr_address  (m_wr_address),
    .m_data_out    (m_data_out),
    .m_data_in     (m_data_in),
    .m_rdata_valid (m_rdata_valid),
    .m_busy        (m_busy)
  );

  always #5 clock = ~clock;

  // Drive a request before edge N, return 1 time unit after edge N.
  task automatic issue(input logic wen, input logic [AW-1:0] waddr,
                       input logic [DW-1:0] wdata, input logic ren,
                       input logic [AW-1:0] raddr);
    @(negedge clock);
    m_wen = wen; m_wr_address = waddr; m_data_out = wdata;
    m_ren = ren; m_rd_address = raddr;
    @(posedge clock);
    #1;
    m_wen = 1'b0; m_ren = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs 'lat' edges after a request; valid must pulse only on the last.
  task automatic run_op(input string name, input int lat, input logic expect_pulse,
                        input logic [DW-1:0] exp_data);
    for (int k = 1; k <= lat; k++) begin
      step();
      tests_run++;
      if (m_busy !== (k < lat)) begin
        failed++;
        $display("FAIL %s busy@+%0d got=%b exp=%b", name, k, m_busy, (k < lat));
      end
      tests_run++;
      if (m_rdata_valid !== (expect_pulse && k == lat)) begin
        failed++;
        $display("FAIL %s valid@+%0d got=%b exp=%b", name, k, m_rdata_valid,
                 (expect_pulse && k == lat));
      end
    end
    if (expect_pulse) begin
      tests_run++;
      if (m_data_in !== exp_data) begin
        failed++;
        $display("FAIL %s data got=%h exp=%h", name, m_data_in, exp_data);
      end
      step();
      tests_run++;
      if (m_rdata_valid !== 1'b0 || m_data_in !== exp_data) begin
        failed++;
        $display("FAIL %s hold got valid=%b data=%h exp valid=0 data=%h",
                 name, m_rdata_valid, m_data_in, exp_data);
      end
    end
  endtask

  task automatic do_write(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
    issue(1'b1, a, d, 1'b0, '0);
    run_op(name, WL, 1'b0, '0);
  endtask

  task automatic do_read(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    issue(1'b0, '0, '0, 1'b1, a);
    run_op(name, RL, 1'b1, exp);
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    step(); step();
    @(negedge clock);
    reset = 1'b0;
    tests_run++;
    if (m_busy !== 1'b0 || m_rdata_valid !== 1'b0 || m_data_in !== '0) begin
      failed++;
      $display("FAIL reset got busy=%b valid=%b data=%h exp 0/0/0",
               m_busy, m_rdata_valid, m_data_in);
    end
  endtask

  task automatic test_write_alone();
    do_write("wr_3c0", 12'h3C0, 32'hDEAD_BEEF);
    do_read("rd_3c0", 12'h3C0, 32'hDEAD_BEEF);
  endtask

  task automatic test_read_latency();
    do_write("pre_0a5", 12'h0A5, 32'h1234_5678);
    do_read("rd_0a5", 12'h0A5, 32'h1234_5678);
    do_read("rd_0a5_again", 12'h0A5, 32'h1234_5678);
  endtask

  task automatic test_combined();
    do_write("pre_220", 12'h220, 32'h0000_0042);
    issue(1'b1, 12'h110, 32'hCAFE_0001, 1'b1, 12'h220);
    run_op("comb_220", WL + RL, 1'b1, 32'h0000_0042);
    do_read("rd_110", 12'h110, 32'hCAFE_0001);
  endtask

  task automatic test_same_addr();
    do_write("pre_055", 12'h055, 32'h0000_0000);
    issue(1'b1, 12'h055, 32'hA5A5_A5A5, 1'b1, 12'h055);
    run_op("comb_055", WL + RL, 1'b1, 32'hA5A5_A5A5);
  endtask

  task automatic test_reset_mid_read();
    do_write("pre_001", 12'h001, 32'h0BAD_F00D);
    issue(1'b0, '0, '0, 1'b1, 12'h001);
    step();
    tests_run++;
    if (m_busy !== 1'b1) begin
      failed++;
      $display("FAIL rst_rd busy_before got=%b exp=1", m_busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++;
    if (m_busy !== 1'b0 || m_rdata_valid !== 1'b0 || m_data_in !== '0) begin
      failed++;
      $display("FAIL rst_rd after got busy=%b valid=%b data=%h exp 0/0/0",
               m_busy, m_rdata_valid, m_data_in);
    end
    for (int k = 0; k < RL + 2; k++) begin
      step();
      tests_run++;
      if (m_rdata_valid !== 1'b0 || m_busy !== 1'b0) begin
        failed++;
        $display("FAIL rst_rd quiet@%0d got valid=%b busy=%b exp 0/0",
                 k, m_rdata_valid, m_busy);
      end
    end
    do_read("rd_001_after_rst", 12'h001, 32'h0BAD_F00D);
  endtask

  task automatic test_reset_mid_write();
    do_write("pre_077", 12'h077, 32'h1111_1111);
    issue(1'b1, 12'h077, 32'h2222_2222, 1'b0, '0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++;
    if (m_busy !== 1'b0) begin
      failed++;
      $display("FAIL rst_wr busy got=%b exp=0", m_busy);
    end
    step();
    do_read("rd_077_after_rst", 12'h077, 32'h1111_1111);
  endtask

  task automatic test_busy_ignored();
    int pulses;
    do_write("pre_002", 12'h002, 32'h0000_0002);
    issue(1'b0, '0, '0, 1'b1, 12'h0A5);
    // Second request held for exactly one edge while busy.
    @(negedge clock);
    m_ren = 1'b1; m_rd_address = 12'h002;
    m_wen = 1'b1; m_wr_address = 12'h002; m_data_out = 32'hFFFF_0000;
    pulses = 0;
    for (int k = 1; k <= RL + 6; k++) begin
      step();
      m_ren = 1'b0; m_wen = 1'b0;
      if (m_rdata_valid === 1'b1) begin
        pulses++;
        tests_run++;
        if (k != RL || m_data_in !== 32'h1234_5678) begin
          failed++;
          $display("FAIL busy_ign pulse got edge=+%0d data=%h exp edge=+%0d data=12345678",
                   k, m_data_in, RL);
        end
      end
    end
    tests_run++;
    if (pulses != 1) begin
      failed++;
      $display("FAIL busy_ign pulses got=%0d exp=1", pulses);
    end
    do_read("rd_002_untouched", 12'h002, 32'h0000_0002);
  endtask

  initial begin
    test_reset();
    test_write_alone();
    test_read_latency();
    test_combined();
    test_same_addr();
    test_reset_mid_read();
    test_reset_mid_write();
    test_busy_ignored();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule : tb_backing_mem
